pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register with a valid/ready handshake, an optional skid buffer and a synchronous flush. It is the successor to the fixed-field, enable-only inter-stage registers, and is used between IF/ID/EX/MEM/WB. Control and data fields are packed into one payload vector by the instantiating stage. It adds back-pressure, bubble insertion on flush, and an occupancy report.

Parameters:
PAYLOAD_W, 32, width of the packed payload (instr, pc, operands, control bits), must be at least 1
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready
CLEAR_ON_FLUSH, 0, 1 = flush also zeroes the payload registers; 0 = payload registers hold their value

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  kill stage contents (branch/jump redirect)
in_valid_i  in  1  upstream payload valid
in_ready_o  out  1  stage can accept a payload
in_data_i  in  PAYLOAD_W  upstream payload
out_valid_o  out  1  downstream payload valid
out_ready_i  in  1  downstream accepts
out_data_o  out  PAYLOAD_W  downstream payload
occupancy_o  out  2  entries held: 0, 1 or 2

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Transfers: in_xfer = in_valid_i & in_ready_o; out_xfer = out_valid_o & out_ready_i. Both are sampled at the rising edge.
- Reset values: out_valid_o=0, out_data_o=0, skid register=0, occupancy_o=0, state=EMPTY. in_ready_o=1 after reset; when SKID_EN=1 it is a register that resets to 1. Any in_xfer in a cycle where rst_i=1 is discarded.
- Priority: rst_i > flush_i > normal operation.
- FSM (SKID_EN=1): states EMPTY, BUSY, FULL; the state also drives occupancy_o.
  - EMPTY: in_xfer -> BUSY, main<=in_data_i.
  - BUSY with in_xfer & out_xfer -> BUSY, main<=in_data_i.
  - BUSY with in_xfer only -> FULL, skid<=in_data_i.
  - BUSY with out_xfer only -> EMPTY.
  - FULL: in_ready_o=0. out_xfer -> BUSY, main<=skid.
  - in_ready_o is registered, = (next_state != FULL).
- SKID_EN=0: states EMPTY and BUSY only. in_ready_o = ~out_valid_o | out_ready_i (combinational). occupancy_o never reaches 2.
- out_valid_o is 1 in BUSY and FULL. out_data_o is always the main register.
- Latency: 1 cycle from in_xfer into EMPTY to out_valid_o=1. Throughput: 1 payload/cycle when out_ready_i is held at 1.
- Hold rule: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o must not change.
- Flush:
  - Next state is EMPTY, so out_valid_o=0 and occupancy_o=0 next cycle.
  - in_ready_o=1 next cycle.
  - An in_xfer in the flush cycle is discarded.
  - An out_xfer in the flush cycle is still a valid transfer, because the consumer already sampled it.
  - The skid entry is dropped.
  - With CLEAR_ON_FLUSH=1, main and skid are zeroed; otherwise they hold.
- Flush and reset asserted together: reset wins. The result is identical to flush except the payload is always zeroed.
- Reset mid-operation: all contents are lost next cycle, no partial outputs. No payload is ever duplicated or reordered.
- Assertions for verification:
  - occupancy_o==2 implies in_ready_o==0.
  - out_valid_o == (occupancy_o != 0).

Decomposition:
- Shared package pipe_pkg: typedef enum logic [1:0] stage_state_t {EMPTY=0, BUSY=1, FULL=2}, constant OCC_W=2.
- Per-stage payload struct typedefs (id_ex_payload_t etc.) also live in pipe_pkg, so stages pack and unpack with casts sized to PAYLOAD_W.
- Optional sub-module pipe_stage_ctrl: holds the FSM, in_ready_o, occupancy_o and the main/skid load enables. The top module holds the payload registers and the flush-clear muxing.

Test Plan:
- Reset then stream: rst_i=1 for 2 cycles, then in_valid_i=1 with data 0x11,0x22,0x33, out_ready_i=1 -> out_valid_o rises 1 cycle after the first accept, outputs 0x11,0x22,0x33 on consecutive cycles, occupancy_o stays 1.
- Back-pressure (SKID_EN=1): drive 0xA0,0xA1 while out_ready_i=0 -> occupancy_o=2, in_ready_o=0, out_data_o=0xA0 held. Release out_ready_i -> 0xA0 then 0xA1, in_ready_o returns to 1 after the first drain.
- Flush while FULL: holding 0xB0,0xB1, assert flush_i one cycle with in_valid_i=1 data 0xB2 -> next cycle out_valid_o=0, occupancy_o=0, 0xB2 never appears. With CLEAR_ON_FLUSH=1, out_data_o=0.
- Reset mid-stream: assert rst_i while occupancy_o=2 -> next cycle out_valid_o=0, out_data_o=0, in_ready_o=1. Pending payloads never emerge.
- SKID_EN=0, PAYLOAD_W=8: out_ready_i toggling 1,0,1 with continuous input 0x01..0x04 -> in_ready_o follows ~out_valid_o|out_ready_i in the same cycle, ordering preserved, occupancy_o never reaches 2.
- Random valid/ready with a scoreboard over 10k cycles and random flushes -> no loss, duplication or reordering between flushes. Hold-rule and occupancy assertions never fire.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: handshake FSM states, occupancy width, per-stage payload layouts.
// Stages pack these structs into a PAYLOAD_W vector and cast back on the far side.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_payload_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_payload_t;

  // The encoding of stage_state_t is chosen so the state is the entry count.
  function automatic logic [OCC_W-1:0] occ_of(stage_state_t s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Handshake FSM for one pipeline stage: ready, valid, occupancy and main/skid load enables.
// Valid is registered (1-cycle latency); with SKID_EN ready is registered and a 2nd entry absorbs stalls.
import pipe_pkg::*;

module pipe_stage_ctrl #(
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             main_ld_o,
  output logic             main_from_skid_o,
  output logic             skid_ld_o
);

  stage_state_t state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         in_ready, out_valid, in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = SKID_EN ? in_ready_q : (~out_valid | out_ready_i);
  assign in_xfer   = in_valid_i & in_ready;
  assign out_xfer  = out_valid & out_ready_i;

  always_comb begin
    state_d          = state_q;
    main_ld_o        = 1'b0;
    main_from_skid_o = 1'b0;
    skid_ld_o        = 1'b0;
    if (rst_i || flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = BUSY;
            main_ld_o = 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_ld_o = 1'b1;
          end else if (in_xfer && SKID_EN) begin
            state_d   = FULL;
            skid_ld_o = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d          = BUSY;
            main_ld_o        = 1'b1;
            main_from_skid_o = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign occupancy_o = occ_of(state_q);

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, optional skid entry and synchronous flush.
// 1-cycle latency, full throughput; output payload frozen while stalled, ready drops only when both entries held.
import pipe_pkg::*;

module pipe_stage_reg #(
  parameter int PAYLOAD_W      = 32,
  parameter bit SKID_EN        = 1'b1,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic [OCC_W-1:0]     occupancy_o
);

  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 main_ld, main_from_skid, skid_ld;

  pipe_stage_ctrl #(
    .SKID_EN(SKID_EN)
  ) u_ctrl (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .out_ready_i     (out_ready_i),
    .in_ready_o      (in_ready_o),
    .out_valid_o     (out_valid_o),
    .occupancy_o     (occupancy_o),
    .main_ld_o       (main_ld),
    .main_from_skid_o(main_from_skid),
    .skid_ld_o       (skid_ld)
  );

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (rst_i) begin
      main_d = '0;
      skid_d = '0;
    end else if (flush_i) begin
      // Holding stale payload on flush saves mux toggles; clearing aids debug visibility.
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      if (main_ld) main_d = main_from_skid ? skid_q : in_data_i;
      if (skid_ld) skid_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data_o = main_q;

endmodule
